// File: rtl/qif_syn_current_if.sv
// Spike-event handshake into the synaptic current generator.
interface qif_syn_current_if;
  logic              spk_valid;
  logic signed [7:0] spk_weight;
  logic              spk_ready;

  modport master (output spk_valid, output spk_weight, input spk_ready);
  modport slave  (input spk_valid, input spk_weight, output spk_ready);
endinterface

// File: rtl/qif_syn_current.sv
// Synaptic current for the QIF neuron: 4-deep event FIFO, one pop per cycle,
// leak toward zero on a periodic tick, saturating signed 8-bit output.
module qif_syn_current #(
  parameter int DECAY_SHIFT = 2,
  parameter int TICK_DIV    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  qif_syn_current_if.slave  spk,
  input  logic              syn_en,
  output logic signed [7:0] I_syn,
  output logic              sat,
  output logic [2:0]        fifo_level
);
  localparam int            CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  logic [3:0][7:0]   mem;
  logic [1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]     tick_cnt;
  logic              push, pop, tick;
  logic signed [7:0] w;
  logic [8:0]        mag, m;
  logic signed [9:0] i_ext, w_ext, m_ext, sum;
  logic signed [7:0] nxt;
  logic              nxt_sat;

  // Ready depends only on registered level, so a pop cannot make room for a push.
  assign spk.spk_ready = (fifo_level != 3'd4);
  assign push = spk.spk_valid && spk.spk_ready;
  assign pop  = (fifo_level != 3'd0) && syn_en;
  assign tick = (tick_cnt == TICK_LAST);

  always_comb begin
    w   = pop ? $signed(mem[rd_ptr]) : 8'sd0;
    // 9-bit magnitude so that -128 maps to 128
    mag = I_syn[7] ? (~{1'b1, I_syn} + 9'd1) : {1'b0, I_syn};
    m   = 9'd0;
    if (tick) begin
      m = mag >> DECAY_SHIFT;
      if (m == 9'd0 && I_syn != 8'sd0) m = 9'd1;
    end
    i_ext = $signed({{2{I_syn[7]}}, I_syn});
    w_ext = $signed({{2{w[7]}}, w});
    m_ext = $signed({1'b0, m});
    sum   = I_syn[7] ? (i_ext + m_ext + w_ext) : (i_ext - m_ext + w_ext);
    nxt     = sum[7:0];
    nxt_sat = 1'b0;
    if (sum > 10'sd127) begin
      nxt     = 8'sd127;
      nxt_sat = 1'b1;
    end else if (sum < -10'sd128) begin
      nxt     = -8'sd128;
      nxt_sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      I_syn      <= 8'sd0;
      sat        <= 1'b0;
      fifo_level <= 3'd0;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      tick_cnt   <= '0;
    end else begin
      I_syn    <= nxt;
      sat      <= nxt_sat;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 3'd1;
        2'b01:   fifo_level <= fifo_level - 3'd1;
        default: ;
      endcase
    end
  end

  // Storage is not reset; pointers define what is live.
  always_ff @(posedge clk) begin
    if (!rst_n && push) mem[wr_ptr] <= spk.spk_weight;
  end
endmodule

// File: tb/tb_qif_syn_current.sv
// Randomized and directed bench for qif_syn_current against a queue-based model.
module tb_qif_syn_current;
  localparam int DS = 2;
  localparam int TD = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              syn_en = 1'b0;
  logic signed [7:0] I_syn;
  logic              sat;
  logic [2:0]        fifo_level;

  qif_syn_current_if spk();

  qif_syn_current #(.DECAY_SHIFT(DS), .TICK_DIV(TD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spk        (spk.slave),
    .syn_en     (syn_en),
    .I_syn      (I_syn),
    .sat        (sat),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference state
  int q[$];
  int m_i = 0, m_sat = 0, m_cnt = 0;
  bit mvalid = 0;

  task automatic check(string tag, int obs, int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(bit v, int w, bit en, bit r);
    int pw, mag, m, nx;
    bit tick, psh, pp;
    if (r) begin
      q.delete();
      m_i = 0; m_sat = 0; m_cnt = 0; mvalid = 1;
      return;
    end
    tick = (m_cnt == TD - 1);
    psh  = v && (q.size() < 4);
    pp   = (q.size() > 0) && en;
    pw   = pp ? q[0] : 0;
    mag  = (m_i < 0) ? -m_i : m_i;
    m    = tick ? (mag >> DS) : 0;
    if (tick && m == 0 && m_i != 0) m = 1;
    nx = m_i + pw;
    if (m_i > 0) nx = nx - m;
    else if (m_i < 0) nx = nx + m;
    m_sat = (nx > 127 || nx < -128) ? 1 : 0;
    m_i   = (nx > 127) ? 127 : (nx < -128) ? -128 : nx;
    if (pp) void'(q.pop_front());
    if (psh) q.push_back(w);
    m_cnt = tick ? 0 : m_cnt + 1;
  endtask

  // One clock: drive, check ready, edge, advance model, check registered outputs.
  task automatic cyc(bit v, logic [7:0] w, bit en, bit r);
    spk.spk_valid  = v;
    spk.spk_weight = w;
    syn_en         = en;
    rst_n          = r;
    #1;
    if (mvalid) check("ready", int'(spk.spk_ready), (q.size() < 4) ? 1 : 0);
    @(posedge clk);
    model_step(v, int'($signed(w)), en, r);
    #1;
    check("I_syn", int'(I_syn), m_i);
    check("sat", int'(sat), m_sat);
    check("level", int'(fifo_level), q.size());
  endtask

  task automatic do_reset(int n);
    for (int i = 0; i < n; i++) cyc(1'($urandom), 8'($urandom), 1'($urandom), 1'b1);
  endtask

  initial begin
    int exp_tab[14] = '{30, 23, 18, 14, 11, 9, 7, 6, 5, 4, 3, 2, 1, 0};
    int prev, k;

    // reset with random inputs
    do_reset(2);
    check("rst_I", int'(I_syn), 0);
    check("rst_sat", int'(sat), 0);
    check("rst_level", int'(fifo_level), 0);
    check("rst_ready", int'(spk.spk_ready), 1);

    // single +40 event and its decay trajectory
    cyc(1'b1, 8'd40, 1'b1, 1'b0);
    cyc(1'b0, 8'd0, 1'b1, 1'b0);
    check("ev40", int'(I_syn), 40);
    prev = 40; k = 0;
    for (int i = 0; i < 70; i++) begin
      cyc(1'b0, 8'd0, 1'b1, 1'b0);
      if (int'(I_syn) != prev) begin
        if (k < 14) check("decay", int'(I_syn), exp_tab[k]);
        k++;
        prev = int'(I_syn);
      end
    end
    check("decay_steps", k, 14);
    check("decay_hold0", int'(I_syn), 0);

    // positive saturation
    do_reset(1);
    cyc(1'b1, 8'd100, 1'b1, 1'b0);
    cyc(1'b1, 8'd100, 1'b1, 1'b0);
    check("sat_p100", int'(I_syn), 100);
    cyc(1'b1, 8'd100, 1'b1, 1'b0);
    check("sat_p127", int'(I_syn), 127);
    check("sat_p_flag", int'(sat), 1);
    cyc(1'b0, 8'd0, 1'b1, 1'b0);
    check("sat_p127b", int'(I_syn), 127);
    check("sat_p_flag2", int'(sat), 1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 8'd0, 1'b1, 1'b0);

    // negative saturation and decay from -128
    do_reset(1);
    cyc(1'b1, 8'h80, 1'b1, 1'b0);
    cyc(1'b1, 8'h80, 1'b1, 1'b0);
    check("sat_n128", int'(I_syn), -128);
    check("sat_n_flag0", int'(sat), 0);
    cyc(1'b0, 8'd0, 1'b1, 1'b0);
    check("sat_n_flag1", int'(sat), 1);
    cyc(1'b0, 8'd0, 1'b1, 1'b0);
    check("sat_n96", int'(I_syn), -96);

    // backpressure with syn_en low
    do_reset(1);
    for (int i = 1; i <= 6; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    check("bp_level4", int'(fifo_level), 4);
    check("bp_ready0", int'(spk.spk_ready), 0);
    for (int i = 3; i >= 0; i--) begin
      cyc(1'b0, 8'd0, 1'b1, 1'b0);
      check("bp_drain", int'(fifo_level), i);
    end
    cyc(1'b1, 8'd5, 1'b1, 1'b0);
    cyc(1'b1, 8'd6, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'd0, 1'b1, 1'b0);

    // simultaneous push/pop at level 2
    do_reset(1);
    cyc(1'b1, 8'd7, 1'b0, 1'b0);
    cyc(1'b1, 8'd9, 1'b0, 1'b0);
    cyc(1'b1, 8'd11, 1'b1, 1'b0);
    check("pp_level", int'(fifo_level), 2);
    cyc(1'b1, 8'd13, 1'b1, 1'b0);
    check("pp_level2", int'(fifo_level), 2);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'd0, 1'b1, 1'b0);

    // reset mid-operation
    do_reset(1);
    cyc(1'b1, 8'd50, 1'b1, 1'b0);
    cyc(1'b0, 8'd0, 1'b1, 1'b0);
    check("mr_I50", int'(I_syn), 50);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(20 + i), 1'b0, 1'b0);
    check("mr_level3", int'(fifo_level), 3);
    cyc(1'b0, 8'd0, 1'b1, 1'b1);
    check("mr_I0", int'(I_syn), 0);
    check("mr_level0", int'(fifo_level), 0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'd0, 1'b1, 1'b0);
    check("mr_noreplay", int'(I_syn), 0);
    do_reset(1);
    cyc(1'b1, 8'd40, 1'b1, 1'b0);
    cyc(1'b0, 8'd0, 1'b1, 1'b0);
    check("mr_tick_restart", int'(I_syn), 40);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0, ($urandom % 64) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
